// File: rtl/midi_note_rx.sv
// rtl/midi_note_rx.sv - MIDI 8N1 receiver and single-channel Note On/Off gate decoder
// Optional: define MIDI_RUNNING_STATUS_EN to keep the status byte after each message (running status).
module midi_note_rx #(
  parameter int CLKS_PER_BIT = 3200,
  parameter int CHANNEL      = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_rx,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic [6:0] velocity,
  output logic       msg_strobe,
  output logic       framing_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;

  state_t          state, next_state;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_q;
  logic [7:0]      byte_q;
  logic            byte_strobe;
  logic            tick, byte_done, frame_bad, sample_data;

  logic            have_status, status_on, expect_d2;
  logic [6:0]      note_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], midi_rx};
  end
  assign rx_s = sync_q[1];

  // The start bit is timed to its centre; every later sample is a full bit apart.
  assign tick = (state == S_START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (!rx_s) next_state = S_START;
      S_START:     if (tick) next_state = rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (tick && bit_cnt == 3'd7) next_state = S_STOP;
      S_STOP:      if (tick) next_state = rx_s ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rx_s) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_comb begin
    byte_done   = 1'b0;
    frame_bad   = 1'b0;
    sample_data = 1'b0;
    case (state)
      S_DATA: sample_data = tick;
      S_STOP: begin
        byte_done = tick && rx_s;
        frame_bad = tick && !rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      bit_cnt       <= '0;
      shift_q       <= '0;
      byte_q        <= '0;
      byte_strobe   <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      cnt           <= (state == S_IDLE || tick) ? '0 : cnt + CW'(1);
      byte_strobe   <= byte_done;
      framing_error <= frame_bad;
      if (state == S_IDLE) bit_cnt <= '0;
      else if (sample_data) bit_cnt <= bit_cnt + 3'd1;
      if (sample_data) shift_q <= {rx_s, shift_q[7:1]};
      if (byte_done) byte_q <= shift_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_status <= 1'b0;
      status_on   <= 1'b0;
      expect_d2   <= 1'b0;
      note_q      <= '0;
      midi_data   <= '0;
      midi_valid  <= 1'b0;
      velocity    <= '0;
      msg_strobe  <= 1'b0;
    end else begin
      msg_strobe <= 1'b0;
      if (byte_strobe && byte_q < 8'hF8) begin
        if (byte_q[7]) begin
          have_status <= (byte_q[7:5] == 3'b100) && (byte_q[3:0] == CHANNEL[3:0]);
          status_on   <= byte_q[4];
          expect_d2   <= 1'b0;
        end else if (have_status) begin
          if (!expect_d2) begin
            note_q    <= byte_q[6:0];
            expect_d2 <= 1'b1;
          end else begin
            msg_strobe <= 1'b1;
            expect_d2  <= 1'b0;
`ifndef MIDI_RUNNING_STATUS_EN
            have_status <= 1'b0;
`endif
            if (status_on && byte_q[6:0] != 7'd0) begin
              midi_data  <= {1'b0, note_q};
              velocity   <= byte_q[6:0];
              midi_valid <= 1'b1;
            end else if (midi_valid && midi_data == {1'b0, note_q}) begin
              midi_valid <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_note_rx.sv
// tb/tb_midi_note_rx.sv - scoreboard bench for midi_note_rx at 16 clocks per bit, channel 0
module tb_midi_note_rx;

  localparam int CPB = 16;
  localparam int LAT = 156;  // start-bit drive edge to the cycle msg_strobe is visible

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       midi_rx = 1'b1;
  logic [7:0] midi_data;
  logic       midi_valid;
  logic [6:0] velocity;
  logic       msg_strobe;
  logic       framing_error;

  midi_note_rx #(.CLKS_PER_BIT(CPB), .CHANNEL(0)) dut (
    .clk(clk), .rst_n(rst_n), .midi_rx(midi_rx), .midi_data(midi_data),
    .midi_valid(midi_valid), .velocity(velocity), .msg_strobe(msg_strobe),
    .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [7:0] note; logic [6:0] vel; logic valid;} exp_t;
  exp_t q[$];
  exp_t nxt;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  logic [7:0] m_note = 8'h00;
  logic [6:0] m_vel = 7'h00;
  logic       m_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (framing_error === 1'b1) fe_cnt = fe_cnt + 1;
    if (msg_strobe === 1'b1) begin
      total = total + 1;
      if (q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_msg_strobe at cyc=%0d note=%h vel=%h valid=%b", cyc, midi_data, velocity, midi_valid);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({cyc, midi_data, velocity, midi_valid} !== {e.cyc, e.note, e.vel, e.valid}) begin
          bad = bad + 1;
          $display("FAIL msg_exec got cyc=%0d note=%h vel=%h valid=%b want cyc=%0d note=%h vel=%h valid=%b",
                   cyc, midi_data, velocity, midi_valid, e.cyc, e.note, e.vel, e.valid);
        end
      end
    end
  end

  task automatic plan(input bit on, input logic [7:0] note, input logic [6:0] vel);
    if (on && vel != 7'd0) begin
      m_note = note; m_vel = vel; m_valid = 1'b1;
    end else if (m_valid && note == m_note) begin
      m_valid = 1'b0;
    end
    nxt.note = m_note; nxt.vel = m_vel; nxt.valid = m_valid;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_hi, input bit push);
    logic [9:0] fr;
    fr = {stop_hi, b, 1'b0};
    @(posedge clk); #1;
    if (push) begin
      nxt.cyc = cyc + LAT;
      q.push_back(nxt);
    end
    for (int i = 0; i < 10; i++) begin
      midi_rx = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    midi_rx = 1'b1;
  endtask

  task automatic send_msg(input logic [7:0] st, input logic [7:0] n, input logic [7:0] v);
    bit hit;
    hit = (st[7:5] == 3'b100) && (st[3:0] == 4'd0);
    send_byte(st, 1'b1, 1'b0);
    send_byte(n, 1'b1, 1'b0);
    if (hit) plan(st[4], n, v[6:0]);
    send_byte(v, 1'b1, hit);
  endtask

  task automatic drain(input string tag);
    repeat (200) @(posedge clk);
    #1;
    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL %s missing_msg_strobe pending=%0d want 0", tag, q.size());
      q.delete();
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic [6:0] v, input logic g);
    total = total + 1;
    if ({midi_data, velocity, midi_valid} !== {d, v, g}) begin
      bad = bad + 1;
      $display("FAIL %s got data=%h vel=%h valid=%b want data=%h vel=%h valid=%b",
               tag, midi_data, velocity, midi_valid, d, v, g);
    end
  endtask

  task automatic test_reset;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset_outputs", 8'h00, 7'h00, 1'b0);
    total = total + 1;
    if ({msg_strobe, framing_error} !== 2'b00) begin
      bad = bad + 1;
      $display("FAIL reset_strobes got %b want 00", {msg_strobe, framing_error});
    end
  endtask

  task automatic test_note_on;
    send_msg(8'h90, 8'h3C, 8'h64);
    drain("note_on");
    check_out("note_on_gate", 8'h3C, 7'h64, 1'b1);
  endtask

  task automatic test_last_note;
    send_msg(8'h90, 8'h3C, 8'h64);
    send_msg(8'h90, 8'h40, 8'h50);
    send_msg(8'h80, 8'h3C, 8'h00);
    drain("last_note_a");
    check_out("off_mismatch_keeps_gate", 8'h40, 7'h50, 1'b1);
    send_msg(8'h80, 8'h40, 8'h00);
    drain("last_note_b");
    check_out("off_match_drops_gate", 8'h40, 7'h50, 1'b0);
  endtask

  task automatic test_vel0_and_channel;
    send_msg(8'h90, 8'h3C, 8'h64);
    send_msg(8'h90, 8'h3C, 8'h00);
    drain("vel0");
    check_out("vel0_is_off", 8'h3C, 7'h64, 1'b0);
    send_msg(8'h91, 8'h3C, 8'h64);
    drain("other_channel");
    check_out("other_channel_ignored", 8'h3C, 7'h64, 1'b0);
  endtask

  task automatic test_realtime_and_glitch;
    send_byte(8'h90, 1'b1, 1'b0);
    send_byte(8'hF8, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    send_byte(8'hFE, 1'b1, 1'b0);
    plan(1'b1, 8'h3C, 7'h64);
    send_byte(8'h64, 1'b1, 1'b1);
    drain("realtime");
    check_out("realtime_transparent", 8'h3C, 7'h64, 1'b1);
    send_byte(8'h90, 1'b1, 1'b0);
    send_byte(8'h45, 1'b1, 1'b0);
    @(posedge clk); #1 midi_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 midi_rx = 1'b1;
    repeat (15) @(posedge clk);
    plan(1'b1, 8'h45, 7'h22);
    send_byte(8'h22, 1'b1, 1'b1);
    drain("glitch");
    check_out("glitch_rejected", 8'h45, 7'h22, 1'b1);
  endtask

  task automatic test_framing;
    int fe0;
    fe0 = fe_cnt;
    send_byte(8'h90, 1'b1, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    midi_rx = 1'b0;
    repeat (40) @(posedge clk);
    #1 midi_rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    total = total + 1;
    if (fe_cnt - fe0 !== 1) begin
      bad = bad + 1;
      $display("FAIL framing_error_pulses got %0d want 1", fe_cnt - fe0);
    end
    send_byte(8'h3C, 1'b1, 1'b0);
    plan(1'b1, 8'h3C, 7'h64);
    send_byte(8'h64, 1'b1, 1'b1);
    drain("framing");
    check_out("status_survives_framing", 8'h3C, 7'h64, 1'b1);
    total = total + 1;
    if (fe_cnt - fe0 !== 1) begin
      bad = bad + 1;
      $display("FAIL framing_error_recovery got %0d want 1", fe_cnt - fe0);
    end
  endtask

  task automatic test_reset_mid;
    send_byte(8'h90, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    @(posedge clk); #1 midi_rx = 1'b0;
    repeat (40) @(posedge clk);
    #1 midi_rx = 1'b1;
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_out("async_reset_outputs", 8'h00, 7'h00, 1'b0);
    m_note = 8'h00; m_vel = 7'h00; m_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    send_byte(8'h64, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    send_byte(8'h64, 1'b1, 1'b0);
    drain("reset_mid");
    check_out("partial_discarded", 8'h00, 7'h00, 1'b0);
  endtask

  task automatic test_running_status;
    send_msg(8'h90, 8'h3C, 8'h64);
    send_byte(8'h40, 1'b1, 1'b0);
`ifdef MIDI_RUNNING_STATUS_EN
    plan(1'b1, 8'h40, 7'h50);
    send_byte(8'h50, 1'b1, 1'b1);
    drain("running_status");
    check_out("running_status_on", 8'h40, 7'h50, 1'b1);
`else
    send_byte(8'h50, 1'b1, 1'b0);
    drain("running_status");
    check_out("running_status_off", 8'h3C, 7'h64, 1'b1);
`endif
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_last_note();
    test_vel0_and_channel();
    test_realtime_and_glitch();
    test_framing();
    test_reset_mid();
    test_running_status();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_note_rx.md
Name: midi_note_rx

Overview:
- Front end of the sound path. Receives a raw MIDI serial line (31250 baud, 8N1) and decodes Note On/Off messages for one channel.
- Presents a monophonic note gate: `midi_data` carries the current note and `midi_valid` is held high while that note sounds.
- Drives `midi_player` directly. `midi_valid` is a level gate, not a pulse.

Parameters:
- CLKS_PER_BIT, 3200, clk cycles per MIDI bit (100 MHz / 31250); minimum 8.
- CHANNEL, 0, 4-bit MIDI channel accepted (0..15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- midi_rx  input  1  raw MIDI serial line, idle high, asynchronous to clk
- midi_data  output  8  current note number, bit 7 always 0
- midi_valid  output  1  note gate, high while note held
- velocity  output  7  velocity of the current note
- msg_strobe  output  1  one-cycle pulse on every accepted Note On/Off
- framing_error  output  1  one-cycle pulse when a stop bit is sampled low

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; receiver in IDLE; parser status cleared.
  - Reset mid-byte or mid-message discards all partial state.
- Input sync: `midi_rx` passes through a 2-flop synchroniser, reset value 1. All logic uses the synchronised signal.
- Receiver FSM: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on a synchronised low, go to START and clear the bit counter.
  - START: wait CLKS_PER_BIT/2 (integer divide), then sample. Low goes to DATA; high is a glitch and returns to IDLE.
  - DATA: 8 samples, each CLKS_PER_BIT after the previous, LSB first.
  - STOP: sample CLKS_PER_BIT later.
    - High: byte complete, internal byte strobe for one cycle, go to IDLE.
    - Low: `framing_error` pulses for one cycle, byte discarded, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the line reads high, then go to IDLE.
- Parser (acts on the byte strobe). Byte types:
  - 0xF8–0xFF (realtime): ignored; parser state untouched, even mid-message.
  - 0x8n or 0x9n with n == CHANNEL: latch status, expect data1.
  - Any other status byte (other channel, other type, 0xF0–0xF7): clear status; following data bytes ignored.
  - Data byte (bit7 = 0) with no status latched: ignored.
  - Data byte as data1: latch note, expect data2.
  - Data byte as data2: execute the message.
- Execute, all register updates in the cycle after the data2 byte strobe; `msg_strobe` pulses in that same cycle:
  - Note On, velocity > 0: `midi_data` ← note, `velocity` ← vel, `midi_valid` ← 1. Last-note priority; a new note replaces the old one without dropping the gate.
  - Note Off, or Note On with velocity 0: if the note equals `midi_data` and `midi_valid` is high, `midi_valid` ← 0. `midi_data` and `velocity` keep their values. A note mismatch leaves the gate unchanged, but `msg_strobe` still pulses.
- Latency: from the mid-stop-bit sample of data2 to the gate change is 2 clk cycles (byte strobe, then execute).
- Simultaneous events: byte strobe and `framing_error` are mutually exclusive by construction. `framing_error` does not clear the parser status.

Optional Feature:
- Macro: MIDI_RUNNING_STATUS_EN.
- Defined: after execute, the parser keeps the latched status and the next data byte is treated as data1 (MIDI running status).
- Not defined: the parser clears the status after execute; data bytes that follow are ignored until a new status byte arrives.

Test Plan (CLKS_PER_BIT = 16, CHANNEL = 0):
- Send 0x90 0x3C 0x64 → `midi_valid` = 1, `midi_data` = 0x3C, `velocity` = 0x64. One `msg_strobe` exactly 2 clk after the stop-bit sample of 0x64.
- Send 0x90 0x3C 0x64, then 0x90 0x40 0x50, then 0x80 0x3C 0x00 → gate stays 1 with `midi_data` = 0x40. Then 0x80 0x40 0x00 → gate 0, `midi_data` holds 0x40.
- Send 0x90 0x3C 0x64, then 0x90 0x3C 0x00 → gate 0 (velocity-0 Note On acts as Note Off). Send 0x91 0x3C 0x64 → no change, no `msg_strobe`.
- Send 0x90 0xF8 0x3C 0xFE 0x64 → same result as 0x90 0x3C 0x64. Drive the start bit low for only 4 cycles → no byte received.
- Send a byte with the stop bit forced low → one-cycle `framing_error`, no byte strobe, receiver waits for the line to go high. Assert `rst_n` low mid-byte → all outputs 0 immediately.
- Send 0x90 0x3C 0x64 0x40 0x50 → with MIDI_RUNNING_STATUS_EN: gate 1, `midi_data` = 0x40. Without it: `midi_data` stays 0x3C.
